// File: rtl/hazard_stall_controller_if.sv
// Bundle of pipeline-side signals for the hazard/stall controller.
// master: the pipeline stages driving decode/dest info; slave: the controller.
interface hazard_stall_controller_if #(
    parameter int unsigned REG_ADDR_W = 4,
    parameter int unsigned CNT_W      = 16
);
    logic                  en_forwarding;
    logic                  ID_valid;
    logic [REG_ADDR_W-1:0] ID_src1;
    logic [REG_ADDR_W-1:0] ID_src2;
    logic                  ID_two_src;
    logic                  EXE_wb_en;
    logic                  EXE_mem_read;
    logic [REG_ADDR_W-1:0] EXE_dst;
    logic                  MEM_wb_en;
    logic [REG_ADDR_W-1:0] MEM_dst;
    logic                  mem_req;
    logic                  hazard_stall;
    logic                  mem_stall;
    logic                  mem_ready;
    logic [CNT_W-1:0]      stall_count;

    modport master (
        output en_forwarding, ID_valid, ID_src1, ID_src2, ID_two_src,
        output EXE_wb_en, EXE_mem_read, EXE_dst, MEM_wb_en, MEM_dst, mem_req,
        input  hazard_stall, mem_stall, mem_ready, stall_count
    );

    modport slave (
        input  en_forwarding, ID_valid, ID_src1, ID_src2, ID_two_src,
        input  EXE_wb_en, EXE_mem_read, EXE_dst, MEM_wb_en, MEM_dst, mem_req,
        output hazard_stall, mem_stall, mem_ready, stall_count
    );
endinterface

// File: rtl/hazard_stall_controller.sv
// Hazard/stall controller: RAW hazard detection in ID, SRAM wait FSM that
// freezes the whole pipeline, and a saturating stalled-cycle counter.
module hazard_stall_controller #(
    parameter int unsigned REG_ADDR_W = 4,
    parameter int unsigned SRAM_WAIT  = 6,
    parameter int unsigned CNT_W      = 16
) (
    input logic                      clk,
    input logic                      rst,
    hazard_stall_controller_if.slave bus
);
    // Wait counter only ever holds SRAM_WAIT-2; keep at least one bit.
    localparam int unsigned WaitW = (SRAM_WAIT > 2) ? $clog2(SRAM_WAIT - 1) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StDone
    } state_e;

    state_e                state_q, state_d;
    logic [WaitW-1:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0]      stall_count_q, stall_count_d;

    logic [REG_ADDR_W-1:0] src1, src2, exe_dst, mem_dst;
    logic                  m1x, m2x, m1m, m2m;
    logic                  hazard_raw;
    logic                  mem_stall;
    logic                  hazard_stall;

    assign src1    = bus.ID_src1;
    assign src2    = bus.ID_src2;
    assign exe_dst = bus.EXE_dst;
    assign mem_dst = bus.MEM_dst;

    // Source/destination match terms and the forwarding-aware hazard decision.
    always_comb begin
        m1x = (src1 == exe_dst) && bus.EXE_wb_en;
        m2x = bus.ID_two_src && (src2 == exe_dst) && bus.EXE_wb_en;
        m1m = (src1 == mem_dst) && bus.MEM_wb_en;
        m2m = bus.ID_two_src && (src2 == mem_dst) && bus.MEM_wb_en;
        if (bus.en_forwarding) begin
            // Only load-use cannot be bypassed; MEM results are always forwardable.
            hazard_raw = bus.ID_valid && bus.EXE_mem_read && (m1x || m2x);
        end else begin
            hazard_raw = bus.ID_valid && (m1x || m2x || m1m || m2m);
        end
    end

    assign mem_stall    = (state_q == StWait);
    // A frozen pipeline makes the hazard moot; it is re-evaluated after release.
    assign hazard_stall = hazard_raw && !mem_stall;

    assign bus.hazard_stall = hazard_stall;
    assign bus.mem_stall    = mem_stall;
    assign bus.mem_ready    = (state_q == StDone);
    assign bus.stall_count  = stall_count_q;

    // SRAM access FSM: requests are only accepted in idle, never queued.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (bus.mem_req) begin
                    state_d = StWait;
                    cnt_d   = WaitW'(SRAM_WAIT - 2);
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - WaitW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Saturating count of cycles in which any stall is active.
    always_comb begin
        stall_count_d = stall_count_q;
        if ((hazard_stall || mem_stall) && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
    end

    // State registers; reset abandons any in-flight access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            stall_count_q <= stall_count_d;
        end
    end
endmodule

// File: tb/tb_hazard_stall_controller.sv
// Self-checking bench: behavioural model of hazard rules, access freeze window
// and saturating counter, compared every cycle, plus directed literal checks.
module tb_hazard_stall_controller;
    localparam int unsigned RegW     = 4;
    localparam int unsigned SramWait = 6;
    localparam int unsigned CntW     = 6;
    localparam int          MaxCnt   = (1 << CntW) - 1;

    logic clk;
    logic rst;

    hazard_stall_controller_if #(.REG_ADDR_W(RegW), .CNT_W(CntW)) bus ();

    hazard_stall_controller #(
        .REG_ADDR_W(RegW),
        .SRAM_WAIT (SramWait),
        .CNT_W     (CntW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: freeze cycles still to come, pending ready pulse, stall tally.
    int m_freeze = 0;
    int m_ready  = 0;
    int m_count  = 0;

    logic       s_haz, s_stall, s_ready;
    logic [CntW-1:0] s_count;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_hazard();
        logic m1x, m2x, m1m, m2m, raw;
        m1x = (bus.ID_src1 == bus.EXE_dst) && bus.EXE_wb_en;
        m2x = bus.ID_two_src && (bus.ID_src2 == bus.EXE_dst) && bus.EXE_wb_en;
        m1m = (bus.ID_src1 == bus.MEM_dst) && bus.MEM_wb_en;
        m2m = bus.ID_two_src && (bus.ID_src2 == bus.MEM_dst) && bus.MEM_wb_en;
        if (bus.en_forwarding) raw = bus.ID_valid && bus.EXE_mem_read && (m1x || m2x);
        else                   raw = bus.ID_valid && (m1x || m2x || m1m || m2m);
        return raw && (m_freeze == 0);
    endfunction

    // Called at a negedge with inputs set; compares, advances model over one posedge.
    task automatic cycle();
        logic exp_h, req, stalled;
        #1;
        exp_h   = model_hazard();
        s_haz   = bus.hazard_stall;
        s_stall = bus.mem_stall;
        s_ready = bus.mem_ready;
        s_count = bus.stall_count;
        check("hazard_stall", 32'(s_haz), 32'(exp_h));
        check("mem_stall", 32'(s_stall), 32'(m_freeze > 0));
        check("mem_ready", 32'(s_ready), 32'(m_ready));
        check("stall_count", 32'(s_count), 32'(m_count));
        req     = bus.mem_req;
        stalled = exp_h || (m_freeze > 0);
        @(posedge clk);
        if (stalled && m_count != MaxCnt) m_count++;
        if (m_freeze > 0) begin
            m_freeze--;
            if (m_freeze == 0) m_ready = 1;
        end else if (m_ready != 0) begin
            m_ready = 0;
        end else if (req) begin
            m_freeze = SramWait - 1;
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.en_forwarding = 1'b0;
        bus.ID_valid      = 1'b0;
        bus.ID_src1       = '0;
        bus.ID_src2       = '0;
        bus.ID_two_src    = 1'b0;
        bus.EXE_wb_en     = 1'b0;
        bus.EXE_mem_read  = 1'b0;
        bus.EXE_dst       = '0;
        bus.MEM_wb_en     = 1'b0;
        bus.MEM_dst       = '0;
        bus.mem_req       = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_mem_stall", 32'(bus.mem_stall), 32'd0);
        check("rst_mem_ready", 32'(bus.mem_ready), 32'd0);
        check("rst_stall_count", 32'(bus.stall_count), 32'd0);
        m_freeze = 0;
        m_ready  = 0;
        m_count  = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One access request held for 'hold' cycles; records 8 cycles after the request.
    task automatic run_access(input int hold, output logic [7:0] sv, output logic [7:0] rv,
                              output logic [7:0] hv);
        bus.mem_req = 1'b1;
        cycle();
        for (int i = 0; i < 8; i++) begin
            if (i + 1 >= hold) bus.mem_req = 1'b0;
            cycle();
            sv[i] = s_stall;
            rv[i] = s_ready;
            hv[i] = s_haz;
        end
    endtask

    logic [7:0] sv, rv, hv;

    initial begin
        rst = 1'b1;
        idle_inputs();
        do_reset();

        // Load-use with forwarding on, then plain ALU result (bypassable).
        bus.en_forwarding = 1'b1; bus.ID_valid = 1'b1; bus.ID_src1 = 4'd3;
        bus.EXE_dst = 4'd3; bus.EXE_wb_en = 1'b1; bus.EXE_mem_read = 1'b1;
        bus.MEM_dst = 4'd9;
        cycle(); check("t1_load_use", 32'(s_haz), 32'd1);
        bus.EXE_mem_read = 1'b0;
        cycle(); check("t1_alu_fwd", 32'(s_haz), 32'd0);

        // Forwarding off: MEM match on src2.
        idle_inputs();
        bus.ID_valid = 1'b1; bus.ID_src1 = 4'd1; bus.ID_src2 = 4'd5; bus.ID_two_src = 1'b1;
        bus.MEM_dst = 4'd5; bus.MEM_wb_en = 1'b1; bus.EXE_dst = 4'd7;
        cycle(); check("t2_mem_src2", 32'(s_haz), 32'd1);
        bus.ID_two_src = 1'b0;
        cycle(); check("t2_one_src", 32'(s_haz), 32'd0);
        bus.ID_two_src = 1'b1; bus.ID_valid = 1'b0;
        cycle(); check("t2_invalid", 32'(s_haz), 32'd0);

        // Single-cycle request.
        idle_inputs();
        do_reset();
        run_access(1, sv, rv, hv);
        check("t3_stall_seq", 32'(sv), 32'h1f);
        check("t3_ready_seq", 32'(rv), 32'h20);
        check("t3_count", 32'(s_count), 32'd5);

        // Request held through WAIT and DONE must not retrigger.
        do_reset();
        run_access(7, sv, rv, hv);
        check("t4_stall_seq", 32'(sv), 32'h1f);
        check("t4_ready_seq", 32'(rv), 32'h20);
        check("t4_count", 32'(s_count), 32'd5);

        // Load-use hazard concurrent with request.
        do_reset();
        bus.en_forwarding = 1'b1; bus.ID_valid = 1'b1; bus.ID_src1 = 4'd3;
        bus.EXE_dst = 4'd3; bus.EXE_wb_en = 1'b1; bus.EXE_mem_read = 1'b1;
        run_access(1, sv, rv, hv);
        check("t5_haz_seq", 32'(hv), 32'he0);
        check("t5_stall_seq", 32'(sv), 32'h1f);

        // Reset during the third WAIT cycle.
        idle_inputs();
        do_reset();
        bus.mem_req = 1'b1;
        cycle();
        bus.mem_req = 1'b0;
        cycle();
        cycle();
        #1;
        check("t6_in_wait", 32'(bus.mem_stall), 32'd1);
        rst = 1'b1;
        #1;
        check("t6_async_stall", 32'(bus.mem_stall), 32'd0);
        check("t6_async_count", 32'(bus.stall_count), 32'd0);
        m_freeze = 0; m_ready = 0; m_count = 0;
        @(negedge clk);
        rst = 1'b0;
        run_access(1, sv, rv, hv);
        check("t6_restart_seq", 32'(sv), 32'h1f);
        check("t6_restart_count", 32'(s_count), 32'd5);

        // Random traffic; narrow register range to get frequent matches.
        for (int n = 0; n < 4000; n++) begin
            bus.en_forwarding = 1'($urandom_range(0, 1));
            bus.ID_valid      = ($urandom_range(0, 3) != 0);
            bus.ID_src1       = RegW'($urandom_range(0, 3));
            bus.ID_src2       = RegW'($urandom_range(0, 3));
            bus.ID_two_src    = 1'($urandom_range(0, 1));
            bus.EXE_wb_en     = 1'($urandom_range(0, 1));
            bus.EXE_mem_read  = 1'($urandom_range(0, 1));
            bus.EXE_dst       = RegW'($urandom_range(0, 3));
            bus.MEM_wb_en     = 1'($urandom_range(0, 1));
            bus.MEM_dst       = RegW'($urandom_range(0, 3));
            bus.mem_req       = ($urandom_range(0, 3) == 0);
            cycle();
        end
        check("sat_count", 32'(s_count), 32'(MaxCnt));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
